// File: rtl/serial_shifter.sv
// Multi-cycle serial shifter: one 1-bit step per clock, start/busy/done handshake,
// registered result and condition codes {s,z,c,v}. Adds rotate-right alongside the ALU barrel shifter.
module serial_shifter #(
    parameter int WIDTH = 16,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       fcode,
    input  logic [SHW-1:0]   shift,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       code
);

    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_SRR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_nxt;
    logic [3:0]       r_op;
    logic [3:0]       w_op_nxt;
    logic [SHW-1:0]   r_cnt;
    logic [SHW-1:0]   w_cnt_nxt;
    logic             r_c_acc;
    logic             w_c_nxt;
    logic             r_v_acc;
    logic             w_v_nxt;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_code;

    logic [WIDTH-1:0] w_step_work;
    logic             w_step_out;
    logic             w_step_v;
    logic             w_load;

    // One 1-bit step of the latched operation; invalid opcodes hold and shift out nothing.
    always_comb begin
        w_step_work = r_work;
        w_step_out  = 1'b0;
        w_step_v    = 1'b0;
        case (r_op)
            OP_SLL: begin
                w_step_work = {r_work[WIDTH-2:0], 1'b0};
                w_step_out  = r_work[WIDTH-1];
                w_step_v    = r_work[WIDTH-1] ^ r_work[WIDTH-2];
            end
            OP_SLR: begin
                w_step_work = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
                w_step_out  = r_work[WIDTH-1];
            end
            OP_SRL: begin
                w_step_work = {1'b0, r_work[WIDTH-1:1]};
                w_step_out  = r_work[0];
            end
            OP_SRA: begin
                w_step_work = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
                w_step_out  = r_work[0];
            end
            OP_SRR: begin
                w_step_work = {r_work[0], r_work[WIDTH-1:1]};
                w_step_out  = r_work[0];
            end
            default: begin
                w_step_work = r_work;
                w_step_out  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        w_c_nxt     = r_c_acc;
        w_v_nxt     = r_v_acc;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_work_nxt  = in;
                    w_op_nxt    = fcode;
                    w_cnt_nxt   = shift;
                    w_c_nxt     = 1'b0;
                    w_v_nxt     = 1'b0;
                    w_state_nxt = (shift != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                w_work_nxt = w_step_work;
                w_c_nxt    = w_step_out;
                w_v_nxt    = r_v_acc | w_step_v;
                w_cnt_nxt  = r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Result and flags are captured on the edge entering DONE so they are valid while done is high.
    assign w_load = (w_state_nxt == DONE) && (r_state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_work   <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_c_acc  <= 1'b0;
            r_v_acc  <= 1'b0;
            r_result <= '0;
            r_code   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
            r_c_acc <= w_c_nxt;
            r_v_acc <= w_v_nxt;
            if (w_load) begin
                r_result <= w_work_nxt;
                r_code   <= {w_work_nxt[WIDTH-1], (w_work_nxt == '0), w_c_nxt, w_v_nxt};
            end
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign code   = r_code;

endmodule

// File: tb/tb_serial_shifter.sv
// Bench for serial_shifter: directed and random operations against a rule-level reference model.
module tb_serial_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  fcode;
    logic [4:0]  shift;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  code;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_shifter #(.WIDTH(16), .SHW(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .fcode  (fcode),
        .shift  (shift),
        .in     (din),
        .busy   (busy),
        .done   (done),
        .result (result),
        .code   (code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-operation arithmetic on the operand, not a per-cycle register model.
    function automatic void model(input logic [3:0] op, input int n, input logic [15:0] x,
                                  output logic [15:0] r, output logic [3:0] cc);
        logic [31:0]        w;
        logic signed [15:0] sx;
        logic               c;
        logic               v;
        logic               b;
        int                 m;
        c = 1'b0;
        v = 1'b0;
        r = x;
        m = n % 16;
        sx = x;
        case (op)
            4'b1000: begin
                w = {16'h0, x} << n;
                r = w[15:0];
                c = (n == 0 || n > 16) ? 1'b0 : x[16-n];
                for (int k = 1; k <= n; k++) begin
                    b = (15 - k >= 0) ? x[15-k] : 1'b0;
                    if (b != x[15]) v = 1'b1;
                end
            end
            4'b1001: begin
                w = {x, x} << m;
                r = w[31:16];
                c = (n == 0) ? 1'b0 : r[0];
            end
            4'b1010: begin
                r = (n >= 16) ? 16'h0000 : (x >> n);
                c = (n == 0 || n > 16) ? 1'b0 : x[n-1];
            end
            4'b1011: begin
                r = sx >>> ((n > 15) ? 15 : n);
                c = (n == 0) ? 1'b0 : x[(n > 16) ? 15 : n-1];
            end
            4'b1100: begin
                w = {x, x} >> m;
                r = w[15:0];
                c = (n == 0) ? 1'b0 : r[15];
            end
            default: r = x;
        endcase
        cc = {r[15], (r == 16'h0000), c, v};
    endfunction

    // Called at a falling edge; returns at the falling edge of the cycle after done.
    task automatic run_op(input string tag, input logic [3:0] op, input int n,
                          input logic [15:0] x, input int interfere_at);
        int          cycles;
        int          busy_low;
        bit          got;
        logic [15:0] er;
        logic [3:0]  ec;
        start = 1'b1;
        fcode = op;
        shift = 5'(n);
        din   = x;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cycles   = 0;
        busy_low = 0;
        got      = 1'b0;
        while (!got && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (!busy) busy_low++;
            if (done) got = 1'b1;
            if (!got && cycles == interfere_at) begin
                start = 1'b1;
                fcode = 4'b1000;
                shift = 5'd1;
                din   = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
        end
        model(op, n, x, er, ec);
        check({tag, "_latency"}, 32'(cycles), 32'(n + 1));
        check({tag, "_result"}, {16'h0, result}, {16'h0, er});
        check({tag, "_code"}, {28'h0, code}, {28'h0, ec});
        check({tag, "_busy_low"}, 32'(busy_low), 32'd0);
        @(negedge clk);
        check({tag, "_done_drop"}, {31'h0, done}, 32'd0);
        check({tag, "_busy_drop"}, {31'h0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dones;
        logic [3:0]  rop;
        rst   = 1'b1;
        start = 1'b0;
        fcode = 4'h0;
        shift = 5'd0;
        din   = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_done", {31'h0, done}, 32'd0);
        check("reset_result", {16'h0, result}, 32'h0);
        check("reset_code", {28'h0, code}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op("sll_8001_n1", 4'b1000, 1, 16'h8001, -1);
        run_op("sra_8000_n15", 4'b1011, 15, 16'h8000, -1);
        run_op("srr_0001_n1", 4'b1100, 1, 16'h0001, -1);
        run_op("slr_8000_n17", 4'b1001, 17, 16'h8000, -1);
        run_op("srl_1234_n0", 4'b1010, 0, 16'h1234, -1);
        run_op("srl_ffff_n20", 4'b1010, 20, 16'hFFFF, -1);
        run_op("sll_4000_n31", 4'b1000, 31, 16'h4000, -1);
        run_op("bad_8000_n3", 4'b0011, 3, 16'h8000, -1);
        run_op("sll_0001_n5_busy_start", 4'b1000, 5, 16'h0001, 2);
        run_op("sra_7f00_n4_back2back", 4'b1011, 4, 16'h7F00, -1);

        // Reset in the middle of an operation abandons it.
        start = 1'b1;
        fcode = 4'b1010;
        shift = 5'd10;
        din   = 16'hABCD;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'h0, busy}, 32'd0);
        check("midrst_result", {16'h0, result}, 32'h0);
        check("midrst_code", {28'h0, code}, 32'h0);
        rst   = 1'b0;
        dones = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        run_op("after_rst_slr_00f1_n4", 4'b1001, 4, 16'h00F1, -1);

        // Simultaneous reset and start: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        fcode = 4'b1000;
        shift = 5'd3;
        din   = 16'h0001;
        @(negedge clk);
        check("rst_start_busy", {31'h0, busy}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_idle", {31'h0, busy}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0: rop = 4'b1000;
                1: rop = 4'b1001;
                2: rop = 4'b1010;
                3: rop = 4'b1011;
                4: rop = 4'b1100;
                default: rop = 4'($urandom_range(0, 7));
            endcase
            run_op($sformatf("rnd%0d_op%0h", i, rop), rop, int'($urandom_range(0, 31)),
                   16'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
